mem_sram_arb2: RTL and testbench

//  Two-requester arbiter in front of one single-port SRAM/ROM word memory
//  (W-bit word, per-byte strobes, 1-cycle read latency, registered ROM err).

---
 rtl/mem_sram_arb2_if.sv | 25 ++
 rtl/mem_sram_arb2.sv | 102 ++++++++++
 tb/tb_mem_sram_arb2.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_sram_arb2_if.sv
// Requester-side bus of mem_sram_arb2: request and payload toward the arbiter,
// grant and routed response back to the requester.
interface mem_sram_arb2_if #(
    parameter int WIDTH = 64,
    parameter int AW    = 10
);
    logic               req;
    logic               gnt;
    logic [AW-1:0]      addr;
    logic [WIDTH/8-1:0] wstrb;
    logic [WIDTH-1:0]   wdata;
    logic               rsp;
    logic [WIDTH-1:0]   rdata;
    logic               err;

    modport master (
        output req, addr, wstrb, wdata,
        input  gnt, rsp, rdata, err
    );

    modport slave (
        input  req, addr, wstrb, wdata,
        output gnt, rsp, rdata, err
    );
endinterface

// File: rtl/mem_sram_arb2.sv
// Two-port arbiter in front of a single-port word memory with 1-cycle read latency.
// Port 0 is instruction fetch, port 1 is load/store; one access per cycle, responses routed back by id.
module mem_sram_arb2 #(
    parameter int  WIDTH    = 64,
    parameter int  DEPTH    = 1024,
    parameter int  MODE     = 0,
    parameter int  MAX_WAIT = 4,
    localparam int AW       = $clog2(DEPTH),
    localparam int SW       = WIDTH / 8
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    mem_sram_arb2_if.slave   p0,
    mem_sram_arb2_if.slave   p1,
    output logic             mem_cen,
    output logic [SW-1:0]    mem_wstrb,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_err
);
    localparam int             WCW      = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LIM = WCW'(MAX_WAIT);

    logic           last_q,     last_d;
    logic           rsp_v_q,    rsp_v_d;
    logic           rsp_id_q,   rsp_id_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           gnt0;
    logic           gnt1;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            last_q     <= 1'b1;
            rsp_v_q    <= 1'b0;
            rsp_id_q   <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            last_q     <= last_d;
            rsp_v_q    <= rsp_v_d;
            rsp_id_q   <= rsp_id_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Grant decision; nothing is granted while reset is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (g_resetn) begin
            if (p0.req && p1.req) begin
                if (MODE == 0) begin
                    gnt0 = last_q;
                    gnt1 = !last_q;
                end else begin
                    gnt1 = (wait_cnt_q == WAIT_LIM);
                    gnt0 = !gnt1;
                end
            end else begin
                gnt0 = p0.req;
                gnt1 = p1.req;
            end
        end
    end

    always_comb begin
        last_d     = last_q;
        rsp_v_d    = gnt0 | gnt1;
        rsp_id_d   = gnt1;
        wait_cnt_d = wait_cnt_q;
        if (gnt0 | gnt1) begin
            last_d = gnt1;
        end
        if (!p1.req || gnt1) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_LIM) begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
        end
    end

    always_comb begin
        mem_cen   = gnt0 | gnt1;
        mem_addr  = gnt1 ? p1.addr  : p0.addr;
        mem_wdata = gnt1 ? p1.wdata : p0.wdata;
        mem_wstrb = '0;
        if (gnt1) begin
            mem_wstrb = p1.wstrb;
        end else if (gnt0) begin
            mem_wstrb = p0.wstrb;
        end
    end

    // Response gated by reset so an access in flight at reset never surfaces.
    assign p0.gnt   = gnt0;
    assign p1.gnt   = gnt1;
    assign p0.rsp   = g_resetn & rsp_v_q & !rsp_id_q;
    assign p1.rsp   = g_resetn & rsp_v_q & rsp_id_q;
    assign p0.rdata = mem_rdata;
    assign p1.rdata = mem_rdata;
    assign p0.err   = mem_err;
    assign p1.err   = mem_err;
endmodule

// File: tb/tb_mem_sram_arb2.sv
// Bench for mem_sram_arb2: instance 0 is round-robin, instance 1 is fixed priority,
// each with its own behavioural memory; directed scenarios then randomized traffic.
module tb_mem_sram_arb2;
    localparam int WIDTH    = 64;
    localparam int DEPTH    = 1024;
    localparam int AW       = 10;
    localparam int SW       = 8;
    localparam int MAX_WAIT = 4;

    logic g_clk    = 1'b0;
    logic g_resetn = 1'b0;
    always #5 g_clk = ~g_clk;

    logic [0:0]       req   [2][2];
    logic [AW-1:0]    addr  [2][2];
    logic [SW-1:0]    wstrb [2][2];
    logic [WIDTH-1:0] wdata [2][2];
    wire              gnt   [2][2];
    wire              rsp   [2][2];
    wire              err   [2][2];
    wire [WIDTH-1:0]  rdata [2][2];

    wire              mem_cen   [2];
    wire [SW-1:0]     mem_wstrb [2];
    wire [AW-1:0]     mem_addr  [2];
    wire [WIDTH-1:0]  mem_wdata [2];
    logic [WIDTH-1:0] mem_rdata [2];
    logic             mem_err   [2];
    logic [WIDTH-1:0] mem       [2][DEPTH];
    bit               rom       [2];

    int n_cmp = 0;
    int n_err = 0;

    for (genvar m = 0; m < 2; m++) begin : g_dut
        mem_sram_arb2_if #(.WIDTH(WIDTH), .AW(AW)) p0_if ();
        mem_sram_arb2_if #(.WIDTH(WIDTH), .AW(AW)) p1_if ();
        assign p0_if.req   = req[m][0];
        assign p0_if.addr  = addr[m][0];
        assign p0_if.wstrb = wstrb[m][0];
        assign p0_if.wdata = wdata[m][0];
        assign p1_if.req   = req[m][1];
        assign p1_if.addr  = addr[m][1];
        assign p1_if.wstrb = wstrb[m][1];
        assign p1_if.wdata = wdata[m][1];
        assign gnt[m][0]   = p0_if.gnt;
        assign gnt[m][1]   = p1_if.gnt;
        assign rsp[m][0]   = p0_if.rsp;
        assign rsp[m][1]   = p1_if.rsp;
        assign err[m][0]   = p0_if.err;
        assign err[m][1]   = p1_if.err;
        assign rdata[m][0] = p0_if.rdata;
        assign rdata[m][1] = p1_if.rdata;

        mem_sram_arb2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(m), .MAX_WAIT(MAX_WAIT)) u_dut (
            .g_clk     (g_clk),
            .g_resetn  (g_resetn),
            .p0        (p0_if),
            .p1        (p1_if),
            .mem_cen   (mem_cen[m]),
            .mem_wstrb (mem_wstrb[m]),
            .mem_addr  (mem_addr[m]),
            .mem_wdata (mem_wdata[m]),
            .mem_rdata (mem_rdata[m]),
            .mem_err   (mem_err[m])
        );
    end

    // Single-port memory: read data and ROM-write error one cycle after cen.
    always @(posedge g_clk) begin
        for (int m = 0; m < 2; m++) begin
            if (mem_cen[m]) begin
                mem_rdata[m] <= mem[m][mem_addr[m]];
                mem_err[m]   <= rom[m] && (mem_wstrb[m] != '0);
                if (!rom[m]) begin
                    for (int b = 0; b < SW; b++) begin
                        if (mem_wstrb[m][b]) mem[m][mem_addr[m]][b*8 +: 8] <= mem_wdata[m][b*8 +: 8];
                    end
                end
            end
        end
    end

    // Reference model state for the randomized run.
    logic [WIDTH-1:0] ref_mem   [2][8];
    int               last_port [2];
    int               denied    [2];
    int               pend_port [2];
    bit               pend_read [2];
    logic [WIDTH-1:0] pend_data [2];

    function automatic int winner(int m);
        bit r0 = req[m][0][0];
        bit r1 = req[m][1][0];
        if (r0 && r1) begin
            if (m == 0) return 1 - last_port[m];
            return (denied[m] >= MAX_WAIT) ? 1 : 0;
        end
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic idle_all();
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < 2; p++) begin
                req[m][p]   = 1'b0;
                addr[m][p]  = '0;
                wstrb[m][p] = '0;
                wdata[m][p] = '0;
            end
        end
    endtask

    task automatic apply_reset();
        g_resetn = 1'b0;
        idle_all();
        repeat (2) @(posedge g_clk);
        #1 g_resetn = 1'b1;
    endtask

    task automatic test_reset();
        g_resetn = 1'b0;
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < 2; p++) begin
                req[m][p]   = 1'b1;
                addr[m][p]  = AW'(p + 3);
                wstrb[m][p] = p[0] ? '1 : '0;
            end
        end
        repeat (2) @(posedge g_clk);
        @(negedge g_clk);
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < 2; p++) begin
                n_cmp++;
                if (gnt[m][p] !== 1'b0) begin
                    n_err++;
                    $display("FAIL reset_gnt m%0d p%0d: got %b want 0", m, p, gnt[m][p]);
                end
                n_cmp++;
                if (rsp[m][p] !== 1'b0) begin
                    n_err++;
                    $display("FAIL reset_rsp m%0d p%0d: got %b want 0", m, p, rsp[m][p]);
                end
            end
            n_cmp++;
            if (mem_cen[m] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_cen m%0d: got %b want 0", m, mem_cen[m]);
            end
        end
        apply_reset();
    endtask

    task automatic test_single_read();
        apply_reset();
        mem[0][10'h010] = {8{8'hA5}};
        req[0][0]  = 1'b1;
        addr[0][0] = 10'h010;
        @(negedge g_clk);
        n_cmp++;
        if (gnt[0][0] !== 1'b1 || gnt[0][1] !== 1'b0) begin
            n_err++;
            $display("FAIL single_gnt: got %b%b want 01", gnt[0][1], gnt[0][0]);
        end
        n_cmp++;
        if (mem_cen[0] !== 1'b1 || mem_addr[0] !== 10'h010) begin
            n_err++;
            $display("FAIL single_mem: got cen %b addr %h want 1 010", mem_cen[0], mem_addr[0]);
        end
        @(posedge g_clk);
        #1 req[0][0] = 1'b0;
        @(negedge g_clk);
        n_cmp++;
        if (rsp[0][0] !== 1'b1 || rsp[0][1] !== 1'b0) begin
            n_err++;
            $display("FAIL single_rsp: got p0 %b p1 %b want 1 0", rsp[0][0], rsp[0][1]);
        end
        n_cmp++;
        if (rdata[0][0] !== {8{8'hA5}}) begin
            n_err++;
            $display("FAIL single_rdata: got %h want %h", rdata[0][0], {8{8'hA5}});
        end
    endtask

    task automatic test_rr_alternate();
        apply_reset();
        req[0][0] = 1'b1; addr[0][0] = 10'd1;
        req[0][1] = 1'b1; addr[0][1] = 10'd2;
        for (int i = 0; i < 7; i++) begin
            @(negedge g_clk);
            n_cmp++;
            if (gnt[0][0] !== 1'((i < 6) && (i % 2 == 0)) || gnt[0][1] !== 1'((i < 6) && (i % 2 == 1))) begin
                n_err++;
                $display("FAIL rr_gnt cycle %0d: got %b%b", i, gnt[0][1], gnt[0][0]);
            end
            if (i > 0) begin
                n_cmp++;
                if (rsp[0][(i-1)%2] !== 1'b1 || rsp[0][1-(i-1)%2] !== 1'b0) begin
                    n_err++;
                    $display("FAIL rr_rsp cycle %0d: got p0 %b p1 %b want port %0d", i, rsp[0][0], rsp[0][1], (i-1)%2);
                end
            end
            @(posedge g_clk);
            #1;
            if (i == 5) idle_all();
        end
    endtask

    task automatic test_fixed_prio();
        int seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int peak = 0;
        apply_reset();
        req[1][0] = 1'b1; addr[1][0] = 10'd1;
        req[1][1] = 1'b1; addr[1][1] = 10'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge g_clk);
            n_cmp++;
            if (gnt[1][0] !== 1'(seq[i] == 0) || gnt[1][1] !== 1'(seq[i] == 1)) begin
                n_err++;
                $display("FAIL prio_gnt cycle %0d: got %b%b want port %0d", i, gnt[1][1], gnt[1][0], seq[i]);
            end
            if (int'(g_dut[1].u_dut.wait_cnt_q) > peak) peak = int'(g_dut[1].u_dut.wait_cnt_q);
            @(posedge g_clk);
            #1;
        end
        n_cmp++;
        if (peak != MAX_WAIT) begin
            n_err++;
            $display("FAIL prio_wait_peak: got %0d want %0d", peak, MAX_WAIT);
        end
        idle_all();
    endtask

    task automatic test_write_then_read();
        apply_reset();
        mem[0][5]   = '0;
        req[0][1]   = 1'b1;
        addr[0][1]  = 10'd5;
        wstrb[0][1] = '1;
        wdata[0][1] = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge g_clk);
        n_cmp++;
        if (gnt[0][1] !== 1'b1) begin
            n_err++;
            $display("FAIL wr_gnt: got %b want 1", gnt[0][1]);
        end
        @(posedge g_clk);
        #1;
        idle_all();
        req[0][0]  = 1'b1;
        addr[0][0] = 10'd5;
        @(negedge g_clk);
        n_cmp++;
        if (gnt[0][0] !== 1'b1 || rsp[0][1] !== 1'b1) begin
            n_err++;
            $display("FAIL wr_rd_overlap: got gnt0 %b rsp1 %b want 1 1", gnt[0][0], rsp[0][1]);
        end
        @(posedge g_clk);
        #1 idle_all();
        @(negedge g_clk);
        n_cmp++;
        if (rsp[0][0] !== 1'b1 || rdata[0][0] !== 64'hDEAD_BEEF_DEAD_BEEF) begin
            n_err++;
            $display("FAIL wr_rd_data: got rsp %b data %h want 1 deadbeefdeadbeef", rsp[0][0], rdata[0][0]);
        end
    endtask

    task automatic test_rom_err();
        apply_reset();
        rom[0]      = 1'b1;
        mem[0][7]   = 64'h0123_4567_89AB_CDEF;
        req[0][1]   = 1'b1;
        addr[0][1]  = 10'd7;
        wstrb[0][1] = '1;
        wdata[0][1] = '1;
        @(posedge g_clk);
        #1;
        idle_all();
        req[0][0]  = 1'b1;
        addr[0][0] = 10'd7;
        @(negedge g_clk);
        n_cmp++;
        if (rsp[0][1] !== 1'b1 || err[0][1] !== 1'b1) begin
            n_err++;
            $display("FAIL rom_wr_err: got rsp %b err %b want 1 1", rsp[0][1], err[0][1]);
        end
        @(posedge g_clk);
        #1 idle_all();
        @(negedge g_clk);
        n_cmp++;
        if (rsp[0][0] !== 1'b1 || err[0][0] !== 1'b0 || rdata[0][0] !== 64'h0123_4567_89AB_CDEF) begin
            n_err++;
            $display("FAIL rom_rd: got rsp %b err %b data %h want 1 0 0123456789abcdef", rsp[0][0], err[0][0], rdata[0][0]);
        end
        rom[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req[0][0]  = 1'b1;
        addr[0][0] = 10'd3;
        @(negedge g_clk);
        n_cmp++;
        if (gnt[0][0] !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_gnt: got %b want 1", gnt[0][0]);
        end
        @(posedge g_clk);
        #1 g_resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge g_clk);
            n_cmp++;
            if (rsp[0][0] !== 1'b0 || rsp[0][1] !== 1'b0 || gnt[0][0] !== 1'b0 || mem_cen[0] !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_quiet cycle %0d: got rsp %b%b gnt0 %b cen %b want all 0",
                         i, rsp[0][1], rsp[0][0], gnt[0][0], mem_cen[0]);
            end
            @(posedge g_clk);
            #1;
        end
        g_resetn   = 1'b1;
        req[0][1]  = 1'b1;
        addr[0][1] = 10'd4;
        @(negedge g_clk);
        n_cmp++;
        if (rsp[0][0] !== 1'b0 || rsp[0][1] !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_stale_rsp: got %b%b want 00", rsp[0][1], rsp[0][0]);
        end
        n_cmp++;
        if (gnt[0][0] !== 1'b1 || gnt[0][1] !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_first_tie: got %b%b want 01", gnt[0][1], gnt[0][0]);
        end
        @(posedge g_clk);
        #1 idle_all();
    endtask

    task automatic test_random();
        int w [2];
        apply_reset();
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 8; a++) begin
                mem[m][a]     = {$urandom, $urandom};
                ref_mem[m][a] = mem[m][a];
            end
            last_port[m] = 1;
            denied[m]    = 0;
            pend_port[m] = -1;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge g_clk);
            for (int m = 0; m < 2; m++) begin
                w[m] = winner(m);
                for (int p = 0; p < 2; p++) begin
                    n_cmp++;
                    if (gnt[m][p] !== 1'(w[m] == p)) begin
                        n_err++;
                        $display("FAIL rand_gnt m%0d p%0d cycle %0d: got %b want %b", m, p, cyc, gnt[m][p], w[m] == p);
                    end
                    n_cmp++;
                    if (rsp[m][p] !== 1'(pend_port[m] == p)) begin
                        n_err++;
                        $display("FAIL rand_rsp m%0d p%0d cycle %0d: got %b want %b", m, p, cyc, rsp[m][p], pend_port[m] == p);
                    end
                    if (pend_port[m] == p) begin
                        n_cmp++;
                        if (err[m][p] !== 1'b0 || (pend_read[m] && rdata[m][p] !== pend_data[m])) begin
                            n_err++;
                            $display("FAIL rand_data m%0d p%0d cycle %0d: got err %b data %h want 0 %h",
                                     m, p, cyc, err[m][p], rdata[m][p], pend_data[m]);
                        end
                    end
                end
            end
            @(posedge g_clk);
            for (int m = 0; m < 2; m++) begin
                pend_port[m] = w[m];
                if (w[m] >= 0) begin
                    pend_read[m] = (wstrb[m][w[m]] == '0);
                    pend_data[m] = ref_mem[m][addr[m][w[m]][2:0]];
                    for (int b = 0; b < SW; b++) begin
                        if (wstrb[m][w[m]][b]) ref_mem[m][addr[m][w[m]][2:0]][b*8 +: 8] = wdata[m][w[m]][b*8 +: 8];
                    end
                    last_port[m] = w[m];
                end
                if (req[m][1][0] && w[m] != 1) denied[m] = (denied[m] < MAX_WAIT) ? denied[m] + 1 : MAX_WAIT;
                else denied[m] = 0;
            end
            #1;
            for (int m = 0; m < 2; m++) begin
                for (int p = 0; p < 2; p++) begin
                    if (!req[m][p][0] || w[m] == p) begin
                        req[m][p]   = 1'($urandom_range(0, 3) != 0);
                        addr[m][p]  = AW'($urandom_range(0, 7));
                        wstrb[m][p] = ($urandom_range(0, 1) != 0) ? '0 : SW'($urandom);
                        wdata[m][p] = {$urandom, $urandom};
                    end
                end
            end
        end
        idle_all();
    endtask

    initial begin
        rom[0] = 1'b0;
        rom[1] = 1'b0;
        idle_all();
        test_reset();
        test_single_read();
        test_rr_alternate();
        test_fixed_prio();
        test_write_then_read();
        test_rom_err();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
